// File: rtl/conv_stream_pkg.sv
// Shared types and size helpers for the convolution stream master.
//   state_t : run-sequencer states
//   y_size  : number of results produced for a given X/F length
//   addr_w  : address width for a buffer of a given depth (min 1)
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int y_size(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_tx_chan.sv
// One valid/ready master channel: host-loaded buffer, transfer counter and
// registered valid/data.
//   clk, reset     : clock, async active-low reset
//   i_wr_en/addr/data : host buffer write (addresses >= SIZE dropped)
//   i_start        : launch a run, present element 0 next cycle
//   i_stop         : force valid low (run finished)
//   i_ready        : sink ready
//   o_valid/o_data : registered channel outputs
module stream_tx_chan
  import conv_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = 128,
  parameter int AW    = 7,
  localparam int IW   = addr_w(SIZE),
  localparam int CW   = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam logic [AW:0]   SIZE_A = (AW + 1)'(SIZE);
  localparam logic [CW-1:0] LAST   = CW'(SIZE - 1);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic             w_wr_ok;
  logic             w_xfer;
  logic [CW-1:0]    w_nxt;
  logic [WIDTH-1:0] w_first;
  logic [WIDTH-1:0] w_next;

  assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < SIZE_A);
  assign w_xfer  = r_valid && i_ready;
  assign w_nxt   = r_cnt + 1'b1;
  // A write to element 0 in the start cycle must be what goes out first.
  assign w_first = (w_wr_ok && (i_wr_addr == '0)) ? i_wr_data : r_mem[0];
  assign w_next  = r_mem[w_nxt[IW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[i_wr_addr[IW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_start) begin
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_data  <= w_first;
    end else if (i_stop) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_cnt <= w_nxt;
      if (r_cnt == LAST) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_data <= w_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/conv_stream_master.sv
// Convolution stream master: streams preloaded X and F vectors to the engine
// over two master channels and captures the engine's Y results.
//   clk, reset           : clock, async active-low reset
//   ld_en/sel/addr/data  : host buffer load (IDLE only; sel 0 = X, 1 = F)
//   start, busy, done    : run control / status
//   m_*_x, m_*_f         : X and F master channels
//   s_*_y                : Y slave channel
//   rd_addr, rd_data     : result buffer read port (combinational)
//   y_count              : results captured in the current/last run
//
// state | meaning
// IDLE  | host loads buffers, waits for start
// RUN   | X/F streaming and Y capture in progress
// DONE  | one-cycle completion pulse
module conv_stream_master
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH_X = 8,
  parameter int DATA_WIDTH_F = 8,
  parameter int X_SIZE       = 128,
  parameter int F_SIZE       = 32,
  parameter int ACC_SIZE     = 21,
  localparam int Y_SIZE      = y_size(X_SIZE, F_SIZE),
  localparam int LD_AW       = addr_w(X_SIZE),
  localparam int LD_DW       = (DATA_WIDTH_X > DATA_WIDTH_F) ? DATA_WIDTH_X : DATA_WIDTH_F,
  localparam int Y_AW        = addr_w(Y_SIZE),
  localparam int Y_CW        = $clog2(Y_SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [LD_AW-1:0]        ld_addr,
  input  logic [LD_DW-1:0]        ld_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  output logic [DATA_WIDTH_X-1:0] m_data_out_x,
  output logic                    m_valid_f,
  input  logic                    m_ready_f,
  output logic [DATA_WIDTH_F-1:0] m_data_out_f,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  input  logic [ACC_SIZE-1:0]     s_data_in_y,
  input  logic [Y_AW-1:0]         rd_addr,
  output logic [ACC_SIZE-1:0]     rd_data,
  output logic [Y_CW-1:0]         y_count
);

  localparam logic [Y_CW-1:0] Y_LAST   = Y_CW'(Y_SIZE - 1);
  localparam logic [Y_AW:0]   Y_SIZE_A = (Y_AW + 1)'(Y_SIZE);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_ready_y;
  logic [Y_CW-1:0]     r_y_cnt;
  logic [ACC_SIZE-1:0] r_ybuf [Y_SIZE];

  logic w_idle;
  logic w_start;
  logic w_stop;
  logic w_ld_x;
  logic w_ld_f;
  logic w_y_hs;

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle && start;
  assign w_stop  = (r_state == DONE);
  assign w_ld_x  = w_idle && ld_en && !ld_sel;
  assign w_ld_f  = w_idle && ld_en && ld_sel;
  // Ready is only ever high in RUN, so this cannot fire outside a run.
  assign w_y_hs  = s_valid_y && r_ready_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready_y <= 1'b0;
      r_y_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_ready_y <= 1'b1;
            r_y_cnt   <= '0;
          end
        end
        RUN: begin
          if (w_y_hs) begin
            r_y_cnt <= r_y_cnt + 1'b1;
            if (r_y_cnt == Y_LAST) begin
              r_state   <= DONE;
              r_ready_y <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_y_hs) r_ybuf[r_y_cnt[Y_AW-1:0]] <= s_data_in_y;
  end

  stream_tx_chan #(
    .WIDTH (DATA_WIDTH_X),
    .SIZE  (X_SIZE),
    .AW    (LD_AW)
  ) u_chan_x (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_ld_x),
    .i_wr_addr (ld_addr),
    .i_wr_data (ld_data[DATA_WIDTH_X-1:0]),
    .i_start   (w_start),
    .i_stop    (w_stop),
    .i_ready   (m_ready_x),
    .o_valid   (m_valid_x),
    .o_data    (m_data_out_x)
  );

  stream_tx_chan #(
    .WIDTH (DATA_WIDTH_F),
    .SIZE  (F_SIZE),
    .AW    (LD_AW)
  ) u_chan_f (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_ld_f),
    .i_wr_addr (ld_addr),
    .i_wr_data (ld_data[DATA_WIDTH_F-1:0]),
    .i_start   (w_start),
    .i_stop    (w_stop),
    .i_ready   (m_ready_f),
    .o_valid   (m_valid_f),
    .o_data    (m_data_out_f)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign s_ready_y = r_ready_y;
  assign y_count   = r_y_cnt;
  assign rd_data   = ({1'b0, rd_addr} < Y_SIZE_A) ? r_ybuf[rd_addr] : '0;

endmodule

// File: tb/tb_conv_stream_master.sv
`timescale 1ns/1ps
module tb_conv_stream_master;

  localparam int XS  = 128;
  localparam int FS  = 32;
  localparam int YS  = XS - FS + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_en = 1'b0;
  logic        ld_sel = 1'b0;
  logic [6:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        m_valid_x;
  logic        m_ready_x = 1'b0;
  logic [7:0]  m_data_out_x;
  logic        m_valid_f;
  logic        m_ready_f = 1'b0;
  logic [7:0]  m_data_out_f;
  logic        s_valid_y = 1'b0;
  logic        s_ready_y;
  logic [20:0] s_data_in_y = '0;
  logic [6:0]  rd_addr = '0;
  logic [20:0] rd_data;
  logic [6:0]  y_count;

  conv_stream_master dut (
    .clk          (clk),
    .reset        (reset),
    .ld_en        (ld_en),
    .ld_sel       (ld_sel),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x),
    .m_data_out_x (m_data_out_x),
    .m_valid_f    (m_valid_f),
    .m_ready_f    (m_ready_f),
    .m_data_out_f (m_data_out_f),
    .s_valid_y    (s_valid_y),
    .s_ready_y    (s_ready_y),
    .s_data_in_y  (s_data_in_y),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .y_count      (y_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffer contents as the host believes them to be.
  int mx [XS];
  int mf [FS];
  // Scoreboard: expected stream order, and what the engine actually received.
  int exp_x[$];
  int exp_f[$];
  int rx_x[$];
  int rx_f[$];

  bit px_stall = 1'b0;
  bit pf_stall = 1'b0;
  int px_d = 0;
  int pf_d = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s21(input logic [20:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd8();
    logic [7:0] b;
    b = 8'($urandom);
    return int'($signed(b));
  endfunction

  function automatic int gold_y(input int n);
    int s = 0;
    for (int k = 0; k < FS; k++) s += mx[n + k] * mf[k];
    return s;
  endfunction

  function automatic int eng_y(input int n);
    int s = 0;
    for (int k = 0; k < FS; k++) s += rx_x[n + k] * rx_f[k];
    return s;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    bit [3:0] p;
    p = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return p[cyc % 4];
    return 1'($urandom_range(0, 1));
  endfunction

  // Monitor: checks every X/F transfer against the scoreboard and that a
  // stalled beat holds its data.
  always @(negedge clk) begin
    if (!reset) begin
      px_stall = 1'b0;
      pf_stall = 1'b0;
    end else begin
      if (px_stall) begin
        check("x_hold_valid", int'(m_valid_x), 1);
        check("x_hold_data", s8(m_data_out_x), px_d);
      end
      if (pf_stall) begin
        check("f_hold_valid", int'(m_valid_f), 1);
        check("f_hold_data", s8(m_data_out_f), pf_d);
      end
      if (m_valid_x && m_ready_x) begin
        rx_x.push_back(s8(m_data_out_x));
        if (exp_x.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL x_extra: got %0d expected no transfer", s8(m_data_out_x));
        end else check("x_seq", s8(m_data_out_x), exp_x.pop_front());
      end
      if (m_valid_f && m_ready_f) begin
        rx_f.push_back(s8(m_data_out_f));
        if (exp_f.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL f_extra: got %0d expected no transfer", s8(m_data_out_f));
        end else check("f_seq", s8(m_data_out_f), exp_f.pop_front());
      end
      px_stall = m_valid_x && !m_ready_x;
      px_d     = s8(m_data_out_x);
      pf_stall = m_valid_f && !m_ready_f;
      pf_d     = s8(m_data_out_f);
    end
  end

  task automatic load(input bit sel, input int addr, input int val);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 7'(addr);
    ld_data = 8'(val);
    if (!sel) mx[addr] = val;
    else if (addr < FS) mf[addr] = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic start_run(input bit with_ld, input int addr, input int val);
    start = 1'b1;
    if (with_ld) begin
      ld_en   = 1'b1;
      ld_sel  = 1'b0;
      ld_addr = 7'(addr);
      ld_data = 8'(val);
      mx[addr] = val;
    end
    exp_x.delete(); exp_f.delete(); rx_x.delete(); rx_f.delete();
    for (int i = 0; i < XS; i++) exp_x.push_back(mx[i]);
    for (int i = 0; i < FS; i++) exp_f.push_back(mf[i]);
    @(posedge clk); #1;
    start = 1'b0;
    ld_en = 1'b0;
  endtask

  task automatic run_loop(input int xmode, input int fmode, input int ymode,
                          input bit inject, input int abort_at);
    int yi = 0;
    int cyc = 0;
    int ndone = 0;
    int tail = -1;
    bit fin = 1'b0;
    while (!fin) begin
      if (abort_at >= 0 && yi == abort_at) begin
        check("pre_abort_ycount", int'(y_count), abort_at);
        reset = 1'b0;
        #1;
        check("abort_valid_x", int'(m_valid_x), 0);
        check("abort_valid_f", int'(m_valid_f), 0);
        check("abort_ready_y", int'(s_ready_y), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_ycount", int'(y_count), 0);
        exp_x.delete(); exp_f.delete();
        s_valid_y = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (done) ndone++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        if (done) ndone++;
        check("abort_no_done", ndone, 0);
        fin = 1'b1;
      end else begin
        m_ready_x = ready_for(xmode, cyc);
        m_ready_f = ready_for(fmode, cyc);
        if (inject) begin
          if (cyc == 10) begin
            start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 7'd100; ld_data = 8'd99;
          end else if (cyc == 11) begin
            start = 1'b0; ld_sel = 1'b1; ld_addr = 7'd20; ld_data = 8'd77;
          end else if (cyc == 12) ld_en = 1'b0;
        end
        if (yi < YS && rx_x.size() >= yi + FS && rx_f.size() == FS &&
            (ymode == 0 || $urandom_range(0, 2) != 0)) begin
          s_valid_y   = 1'b1;
          s_data_in_y = 21'(eng_y(yi));
        end else begin
          s_valid_y   = 1'b0;
          s_data_in_y = 21'($urandom);
        end
        @(negedge clk);
        if (s_valid_y && s_ready_y) yi++;
        if (done) begin
          ndone++;
          check("done_ycount", int'(y_count), YS);
          check("done_busy", int'(busy), 0);
          if (tail < 0) tail = cyc;
        end
        @(posedge clk); #1;
        cyc++;
        if (tail >= 0 && cyc > tail + 3) begin
          fin = 1'b1;
          check("done_pulses", ndone, 1);
          check("busy_after", int'(busy), 0);
        end else if (cyc > 3000) begin
          n_vec++; n_err++;
          $display("FAIL run_timeout: got %0d results expected %0d", yi, YS);
          fin = 1'b1;
        end
      end
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b0;
    m_ready_f = 1'b0;
  endtask

  task automatic verify_results();
    check("ycount", int'(y_count), YS);
    check("x_left", exp_x.size(), 0);
    check("f_left", exp_f.size(), 0);
    for (int n = 0; n < YS; n++) begin
      rd_addr = 7'(n);
      @(negedge clk);
      check("ybuf", s21(rd_data), gold_y(n));
    end
    rd_addr = 7'(YS);
    @(negedge clk);
    check("rd_oob_97", s21(rd_data), 0);
    rd_addr = 7'd127;
    @(negedge clk);
    check("rd_oob_127", s21(rd_data), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int prev0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid_x", int'(m_valid_x), 0);
    check("rst_valid_f", int'(m_valid_f), 0);
    check("rst_ready_y", int'(s_ready_y), 0);
    check("rst_ycount", int'(y_count), 0);
    check("rst_data_x", s8(m_data_out_x), 0);
    check("rst_data_f", s8(m_data_out_f), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // F = 1, X = i; last X written in the start cycle.
    for (int i = 0; i < FS; i++) load(1'b1, i, 1);
    for (int i = 0; i < XS - 1; i++) load(1'b0, i, i);
    start_run(1'b1, XS - 1, XS - 1);
    run_loop(0, 0, 0, 1'b0, -1);
    verify_results();
    rd_addr = 7'd0;
    @(negedge clk);
    check("y0_ramp", s21(rd_data), 496);
    rd_addr = 7'd96;
    @(negedge clk);
    check("y96_ramp", s21(rd_data), 3568);
    @(posedge clk); #1;

    // X ready 1,0,0,1; random F ready; start and loads during RUN ignored.
    start_run(1'b0, 0, 0);
    run_loop(1, 2, 0, 1'b1, -1);
    verify_results();

    // Y offered in IDLE must not be captured.
    prev0 = gold_y(0);
    s_valid_y   = 1'b1;
    s_data_in_y = 21'd12345;
    for (int i = 0; i < FS; i++) load(1'b1, i, -128);
    for (int i = 0; i < XS; i++) load(1'b0, i, -128);
    rd_addr = 7'd0;
    @(negedge clk);
    check("idle_y_ignored", s21(rd_data), prev0);
    check("idle_ycount", int'(y_count), YS);
    @(posedge clk); #1;
    s_valid_y = 1'b0;
    start_run(1'b0, 0, 0);
    run_loop(2, 2, 1, 1'b0, -1);
    verify_results();
    rd_addr = 7'd50;
    @(negedge clk);
    check("y50_neg", s21(rd_data), 524288);
    @(posedge clk); #1;

    // Random data; out-of-range F write aliases to F[8] if not dropped.
    for (int i = 0; i < FS; i++) load(1'b1, i, rnd8());
    for (int i = 0; i < XS; i++) load(1'b0, i, rnd8());
    load(1'b1, 40, mf[8] + 1);
    start_run(1'b0, 0, 0);
    run_loop(2, 2, 1, 1'b0, -1);
    verify_results();

    // Reset after 40 results, then a fresh complete run.
    for (int i = 0; i < FS; i++) load(1'b1, i, rnd8());
    for (int i = 0; i < XS; i++) load(1'b0, i, rnd8());
    start_run(1'b0, 0, 0);
    run_loop(0, 0, 0, 1'b0, 40);
    start_run(1'b0, 0, 0);
    run_loop(0, 2, 1, 1'b0, -1);
    verify_results();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_stream_master.md
Name: conv_stream_master

Overview:
- Initiator/driver side of the convolution stream interfaces.
- Holds host-preloaded X and F vectors and transmits them over two valid/ready master channels into the convolution engine.
- Accepts the engine's Y output stream as a slave, captures every result into a buffer and signals completion.
- Used as the on-chip stimulus/collection front-end and as the system-level driver for the convolution engine.

Parameters:
- DATA_WIDTH_X, 8: X sample width (signed).
- DATA_WIDTH_F, 8: F coefficient width (signed).
- X_SIZE, 128: X samples per run.
- F_SIZE, 32: F coefficients per run.
- ACC_SIZE, 21: Y result width (signed).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_en  in  1  host buffer write strobe.
- ld_sel  in  1  0 = write X buffer, 1 = write F buffer.
- ld_addr  in  $clog2(X_SIZE)  buffer write address.
- ld_data  in  max(DATA_WIDTH_X, DATA_WIDTH_F)  write data; low bits used.
- start  in  1  run request pulse.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when the last Y is captured.
- m_valid_x  out  1  X channel valid.
- m_ready_x  in  1  X channel ready.
- m_data_out_x  out  DATA_WIDTH_X  X sample.
- m_valid_f  out  1  F channel valid.
- m_ready_f  in  1  F channel ready.
- m_data_out_f  out  DATA_WIDTH_F  F coefficient.
- s_valid_y  in  1  Y channel valid.
- s_ready_y  out  1  Y channel ready.
- s_data_in_y  in  ACC_SIZE  Y result.
- rd_addr  in  $clog2(Y_SIZE)  result buffer read address.
- rd_data  out  ACC_SIZE  result read data, combinational.
- y_count  out  $clog2(Y_SIZE+1)  number of Y captured in the current or last run.

Behaviour:
- Y_SIZE = X_SIZE - F_SIZE + 1 (97 at defaults).
- Reset asserted (low): state = IDLE; busy, done, m_valid_x, m_valid_f, s_ready_y, counters and y_count = 0; data outputs = 0. Buffer contents are not reset.
- State machine IDLE -> RUN -> DONE -> IDLE.
  - IDLE: ld_en writes the X or F buffer. Writes with ld_sel = 1 and ld_addr >= F_SIZE are dropped. start moves to RUN, clears x_cnt, f_cnt, y_cnt and y_count.
  - RUN: busy = 1. ld_en and start are ignored.
  - DONE: lasts one cycle; done = 1, busy = 0; then IDLE.
- X/F channels (identical, independent):
  - m_valid and m_data are registered.
  - m_valid rises 1 cycle after start is accepted, carrying element 0.
  - A transfer happens when valid and ready are both high at a clock edge. On transfer the count increments and the next element is presented in the following cycle with no bubble.
  - While valid is high and ready is low, valid and data hold stable.
  - After element X_SIZE-1 (resp. F_SIZE-1) transfers, valid drops in the next cycle and stays low for the rest of the run.
  - The F and X channels run concurrently; neither waits on the other.
- Y channel:
  - s_ready_y = 1 exactly in RUN while y_cnt < Y_SIZE.
  - On handshake, ybuf[y_cnt] <= s_data_in_y and y_cnt increments; y_count mirrors y_cnt.
  - The handshake that makes y_cnt == Y_SIZE moves the FSM to DONE on the next edge.
  - s_valid_y outside RUN is never accepted.
- Completion requires all Y captured. X/F channels being drained alone does not end the run.
- Simultaneous start and ld_en in IDLE: the write completes and the run starts; data written that cycle is transmitted.
- Reset mid-run: valid/ready drop immediately (asynchronous); no partial done pulse.
- rd_data = ybuf[rd_addr]; addresses >= Y_SIZE return 0.

Decomposition:
- Package conv_stream_pkg holds:
  - the Y_SIZE and address-width localparam helpers;
  - the state enum {IDLE, RUN, DONE}.
- Sub-module stream_tx_chan: buffer, counter and registered valid/data for one master channel. Parameterised by WIDTH/SIZE and instantiated for X and F.

Test Plan:
- Load F = all 1, X[i] = i; start; ideal sink (always ready, returns the golden convolution): Y[0] = 496, Y[96] = 3568, y_count = 97, single done pulse.
- m_ready_x toggled 1,0,0,1 pattern: m_data_out_x is stable across stalls, every X value 0..127 is sent exactly once, in order.
- F = all -128, X = all -128: every captured Y = 524288; no width truncation in ybuf.
- start asserted during RUN and ld_en during RUN: ignored; buffers and counts unchanged.
- reset low at Y #40: all valid/ready go to 0 immediately, y_count = 0, done stays 0; a fresh start then completes with 97 results.
- F write at ld_addr = 40: dropped; F[8] unchanged after the run and the transmitted F sequence.
